sd_burst_manager: RTL and testbench

- Executes READSD/WRITESD instructions as multi-byte bursts against the byte-wide SD controller.
- Serialises one instruction into NBYTES sequential byte transactions at consecutive SD addresses.
- Stalls the pipeline while the burst runs, then writes the assembled little-endian word back to the register file.
- Sits between the decode/execute stage and the SD controller. It generalises the single-byte combinational dispatcher into a sequenced, timed-out burst engine.

---
 rtl/sd_burst_manager.sv | 136 +++++++++++++
 tb/tb_sd_burst_manager.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_burst_manager.sv
// Burst engine for READSD/WRITESD: one instruction becomes NBYTES byte transactions
// against the byte-wide SD controller, with a per-byte timeout and one register writeback.
module sd_burst_manager #(
  parameter int          NBYTES     = 4,
  parameter int          ADDR_WIDTH = 32,
  parameter int          TIMEOUT    = 65535,
  parameter logic [5:0]  READ_OP    = 6'b110000,
  parameter logic [5:0]  WRITE_OP   = 6'b110001
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inst_valid,
  input  logic [31:0]           inst,
  input  logic [31:0]           rs,
  input  logic [31:0]           rt,
  output logic                  stall,
  output logic                  enable,
  output logic                  float,
  output logic [4:0]            addr,
  output logic [31:0]           data,
  output logic                  error,
  input  logic [7:0]            sd_read_data,
  output logic [7:0]            sd_write_data,
  output logic [ADDR_WIDTH-1:0] sd_addr,
  output logic                  sd_read,
  output logic                  sd_write,
  input  logic                  sd_ready
);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, GAP, DONE} state_t;

  state_t                state, state_nx;
  logic [ADDR_WIDTH-1:0] base;
  logic [31:0]           wbuf;
  logic [31:0]           rbuf;
  logic [4:0]            dest;
  logic                  wr;
  logic [1:0]            idx;
  logic [TW-1:0]         tcnt;
  logic                  err;
  logic [5:0]            op;
  logic                  accept;
  logic                  last_byte;
  logic                  expired;
  logic                  unused_bits;

  assign op          = inst[31:26];
  assign accept      = inst_valid && (op == READ_OP || op == WRITE_OP);
  assign last_byte   = (idx == 2'(NBYTES - 1));
  assign expired     = (tcnt == TW'(TIMEOUT - 1));
  assign unused_bits = ^{inst[25:21], inst[15:0]};

  assign float         = 1'b0;
  assign addr          = dest;
  assign data          = rbuf;
  assign error         = err;
  assign sd_addr       = base + ADDR_WIDTH'(idx);
  assign sd_write_data = wbuf[{idx, 3'b000} +: 8];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Requests and strobes decode straight from state so reset drops them without a clock.
  always_comb begin
    state_nx = state;
    stall    = 1'b0;
    enable   = 1'b0;
    sd_read  = 1'b0;
    sd_write = 1'b0;
    case (state)
      IDLE: if (accept) state_nx = REQ;
      REQ: begin
        stall    = 1'b1;
        sd_read  = !wr;
        sd_write = wr;
        if (sd_ready)     state_nx = GAP;
        else if (expired) state_nx = DONE;
      end
      GAP: begin
        stall    = 1'b1;
        state_nx = last_byte ? DONE : REQ;
      end
      DONE: begin
        stall    = 1'b1;
        enable   = !wr;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base <= '0;
      wbuf <= '0;
      rbuf <= '0;
      dest <= '0;
      wr   <= 1'b0;
      idx  <= '0;
      tcnt <= '0;
      err  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          base <= ADDR_WIDTH'(rs);
          wbuf <= rt;
          rbuf <= '0;
          dest <= inst[20:16];
          wr   <= (op == WRITE_OP);
          idx  <= '0;
          tcnt <= '0;
          err  <= 1'b0;
        end
        REQ: begin
          // An ack landing on the last allowed cycle still counts as success.
          if (sd_ready) begin
            if (!wr) rbuf[{idx, 3'b000} +: 8] <= sd_read_data;
            tcnt <= '0;
          end else if (expired) begin
            err  <= 1'b1;
            tcnt <= '0;
            if (!wr) rbuf <= 32'hFFFF_FFFF;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        GAP: if (!last_byte) idx <= idx + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_burst_manager.sv
// Scoreboard bench: two instances (4-byte and 2-byte bursts, short timeout), an auto-acking
// controller model, and monitors that pop expected SD transactions and writebacks.
module tb_sd_burst_manager;
  localparam logic [5:0] RD_OP = 6'b110000;
  localparam logic [5:0] WR_OP = 6'b110001;

  typedef struct { int unit; bit wr; logic [31:0] a; logic [7:0] d; } sd_exp_t;
  typedef struct { int unit; logic [4:0] a; logic [31:0] d; } wb_exp_t;

  logic clk, rst;
  logic [31:0] inst, rs, rt;
  logic [1:0] inst_valid, sd_ready, stall, enable, flt, err, sd_rd, sd_wr;
  logic [1:0][31:0] data, sd_addr;
  logic [1:0][7:0] rdata, wdata;
  logic [1:0][4:0] waddr;

  sd_exp_t sd_q[$];
  wb_exp_t wb_q[$];
  logic [7:0] rd_q[$];
  int total = 0, bad = 0;
  int lat = 2;
  int wc[2];
  bit resp_en = 0, idle_pulse = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    sd_burst_manager #(
      .NBYTES(g == 0 ? 4 : 2), .ADDR_WIDTH(32), .TIMEOUT(8),
      .READ_OP(RD_OP), .WRITE_OP(WR_OP)
    ) dut (
      .clk(clk), .rst(rst), .inst_valid(inst_valid[g]), .inst(inst), .rs(rs), .rt(rt),
      .stall(stall[g]), .enable(enable[g]), .float(flt[g]), .addr(waddr[g]), .data(data[g]),
      .error(err[g]), .sd_read_data(rdata[g]), .sd_write_data(wdata[g]), .sd_addr(sd_addr[g]),
      .sd_read(sd_rd[g]), .sd_write(sd_wr[g]), .sd_ready(sd_ready[g])
    );
  end

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic exp_sd(input int u, input bit w, input logic [31:0] a, input logic [7:0] d);
    sd_exp_t e;
    e.unit = u; e.wr = w; e.a = a; e.d = d;
    sd_q.push_back(e);
  endtask

  task automatic exp_wb(input int u, input logic [4:0] a, input logic [31:0] d);
    wb_exp_t e;
    e.unit = u; e.a = a; e.d = d;
    wb_q.push_back(e);
  endtask

  task automatic issue(input int u, input logic [5:0] op, input logic [4:0] dst,
                       input logic [31:0] b, input logic [31:0] w);
    @(posedge clk); #1;
    inst = {op, 5'd0, dst, 16'h0};
    rs = b; rt = w;
    inst_valid[u] = 1'b1;
    @(posedge clk); #1;
    inst_valid[u] = 1'b0;
  endtask

  task automatic run_burst(input int u, output int sc, output int qc);
    sc = 0; qc = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (stall[u]) begin
        sc++;
        if (!sd_rd[u] && !sd_wr[u]) qc++;
      end else break;
    end
  endtask

  // Controller model: acks `lat` cycles into each request, supplying bytes from rd_q.
  initial begin
    sd_ready = '0; rdata = '0; wc[0] = 0; wc[1] = 0;
    forever begin
      @(posedge clk); #1;
      for (int u = 0; u < 2; u++) begin
        sd_ready[u] = 1'b0;
        if (idle_pulse && u == 0) sd_ready[u] = 1'b1;
        else if (resp_en && (sd_rd[u] || sd_wr[u])) begin
          wc[u]++;
          if (wc[u] >= lat) begin
            sd_ready[u] = 1'b1;
            rdata[u] = 8'h00;
            if (rd_q.size() > 0) rdata[u] = rd_q.pop_front();
            wc[u] = 0;
          end
        end else wc[u] = 0;
      end
    end
  end

  // Monitors: every acked byte and every writeback must match the queue head.
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (sd_ready[u] && (sd_rd[u] || sd_wr[u])) begin
        if (sd_q.size() == 0) begin
          total++; bad++;
          $display("FAIL sd_unexpected unit %0d: got addr %h expected none", u, sd_addr[u]);
        end else begin
          sd_exp_t e;
          e = sd_q.pop_front();
          check("sd_unit", u, e.unit);
          check("sd_dir", {31'd0, sd_wr[u]}, {31'd0, e.wr});
          check("sd_addr", sd_addr[u], e.a);
          if (e.wr) check("sd_wdata", {24'd0, wdata[u]}, {24'd0, e.d});
        end
      end
      if (enable[u]) begin
        if (wb_q.size() == 0) begin
          total++; bad++;
          $display("FAIL wb_unexpected unit %0d: got data %h expected none", u, data[u]);
        end else begin
          wb_exp_t e;
          e = wb_q.pop_front();
          check("wb_unit", u, e.unit);
          check("wb_addr", {27'd0, waddr[u]}, {27'd0, e.a});
          check("wb_data", data[u], e.d);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sc, qc, quiet_bad;
    bit found;
    rst = 1; inst_valid = '0; inst = '0; rs = '0; rt = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stall", {31'd0, stall[0]}, 0);
    check("rst_enable", {31'd0, enable[0]}, 0);
    check("rst_sd_read", {31'd0, sd_rd[0]}, 0);
    check("rst_sd_write", {31'd0, sd_wr[0]}, 0);
    check("rst_error", {31'd0, err[0]}, 0);
    check("rst_data", data[0], 0);
    check("rst_addr", {27'd0, waddr[0]}, 0);
    check("rst_sd_addr", sd_addr[0], 0);
    check("rst_wdata", {24'd0, wdata[0]}, 0);
    check("float", {31'd0, flt[0]}, 0);
    @(posedge clk); #1 rst = 0;
    resp_en = 1;

    // 4-byte read, ack 2 cycles into each request
    lat = 2;
    rd_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) exp_sd(0, 0, 32'h100 + i, 8'h00);
    exp_wb(0, 5'd7, 32'h4433_2211);
    issue(0, RD_OP, 5'd7, 32'h100, 32'h0);
    run_burst(0, sc, qc);
    check("rd4_stall_cycles", sc, 13);
    check("rd4_quiet_cycles", qc, 5);

    // 4-byte write
    for (int i = 0; i < 4; i++) exp_sd(0, 1, 32'h20 + i, 8'hD4 - 8'h11 * i[7:0]);
    issue(0, WR_OP, 5'd3, 32'h20, 32'hA1B2_C3D4);
    run_burst(0, sc, qc);
    check("wr4_stall_cycles", sc, 13);
    check("wr4_error", {31'd0, err[0]}, 0);

    // 2-byte read wrapping the address space
    rd_q = '{8'hAA, 8'hBB};
    exp_sd(1, 0, 32'hFFFF_FFFF, 8'h00);
    exp_sd(1, 0, 32'h0000_0000, 8'h00);
    exp_wb(1, 5'd9, 32'h0000_BBAA);
    issue(1, RD_OP, 5'd9, 32'hFFFF_FFFF, 32'h0);
    run_burst(1, sc, qc);
    check("rd2_stall_cycles", sc, 7);

    // timeout: no acks at all
    resp_en = 0;
    exp_wb(0, 5'd5, 32'hFFFF_FFFF);
    issue(0, RD_OP, 5'd5, 32'h40, 32'h0);
    run_burst(0, sc, qc);
    check("to_req_cycles", sc - qc, 8);
    check("to_stall_cycles", sc, 9);
    check("to_error", {31'd0, err[0]}, 1);
    resp_en = 1;
    for (int i = 0; i < 4; i++) exp_sd(0, 1, 32'h50 + i, 8'h04 - i[7:0]);
    issue(0, WR_OP, 5'd1, 32'h50, 32'h0102_0304);
    check("to_error_cleared", {31'd0, err[0]}, 0);
    run_burst(0, sc, qc);
    check("to_next_stall_cycles", sc, 13);

    // ack coinciding with the last allowed cycle wins over the timeout
    lat = 8;
    rd_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    for (int i = 0; i < 4; i++) exp_sd(0, 0, 32'h60 + i, 8'h00);
    exp_wb(0, 5'd2, 32'h0403_0201);
    issue(0, RD_OP, 5'd2, 32'h60, 32'h0);
    run_burst(0, sc, qc);
    check("edge_stall_cycles", sc, 37);
    check("edge_error", {31'd0, err[0]}, 0);

    // reset in the request of byte 2
    lat = 2;
    rd_q = '{8'h55, 8'h66, 8'h77, 8'h88};
    exp_sd(0, 0, 32'h80, 8'h00);
    exp_sd(0, 0, 32'h81, 8'h00);
    issue(0, RD_OP, 5'd4, 32'h80, 32'h0);
    found = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (sd_rd[0] && sd_addr[0] == 32'h82) begin found = 1; break; end
    end
    check("rst_mid_reached", {31'd0, found}, 1);
    rst = 1;
    #1;
    check("rst_mid_sd_read", {31'd0, sd_rd[0]}, 0);
    check("rst_mid_stall", {31'd0, stall[0]}, 0);
    check("rst_mid_enable", {31'd0, enable[0]}, 0);
    @(posedge clk); #1 rst = 0;
    rd_q.delete();
    rd_q = '{8'h9A, 8'hBC, 8'hDE, 8'hF0};
    for (int i = 0; i < 4; i++) exp_sd(0, 0, 32'h90 + i, 8'h00);
    exp_wb(0, 5'd6, 32'hF0DE_BC9A);
    issue(0, RD_OP, 5'd6, 32'h90, 32'h0);
    run_burst(0, sc, qc);
    check("post_rst_stall_cycles", sc, 13);

    // foreign opcode plus a stray ack while idle
    @(negedge clk); idle_pulse = 1;
    issue(0, 6'b000001, 5'd8, 32'h70, 32'h0);
    @(negedge clk); idle_pulse = 0;
    quiet_bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (stall[0] || sd_rd[0] || sd_wr[0] || enable[0]) quiet_bad++;
    end
    check("idle_ignore", quiet_bad, 0);

    repeat (3) @(negedge clk);
    check("sd_queue_drained", sd_q.size(), 0);
    check("wb_queue_drained", wb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
